barrel_scheduler: RTL and testbench

- Owns the pool of barrel instances; decides when each barrel is launched and when it is recalled.
- Issues one-cycle `start` pulses to free slots on a frame-based spawn timer.
- Recalls retired barrels and drains all barrels on game over.
- Sits between the top-level game FSM and the N barrel instances. It drives their `start`/`over` inputs and reads back their 2-bit `state`.

---
 rtl/barrel_pkg.sv | 20 ++
 rtl/spawn_lfsr.sv | 20 ++
 rtl/barrel_scheduler.sv | 126 ++++++++++++
 tb/tb_barrel_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrel_pkg.sv
// Shared encodings for the barrel scheduler and the barrel instances,
// plus the seed and taps of the optional spawn-jitter LFSR.
package barrel_pkg;

    typedef enum logic [1:0] {
        B_INITIAL = 2'b00,
        B_ROLLING = 2'b01,
        B_FALLING = 2'b10
    } barrel_state_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_DRAIN = 2'b10
    } sched_state_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/spawn_lfsr.sv
// 16-bit Galois LFSR that advances once per launch; used only when
// BARREL_SPAWN_JITTER_EN is defined, to add 0..31 frames to the spawn interval.
module spawn_lfsr
    import barrel_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        step,
    output logic [15:0] value
);

    always_ff @(posedge clk) begin
        if (rst) begin
            value <= LFSR_SEED;
        end else if (step) begin
            value <= {1'b0, value[15:1]} ^ (value[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/barrel_scheduler.sv
// Barrel pool scheduler: launches free slots on a frame timer, recalls retired
// barrels, drains on game over. Optional feature macro: BARREL_SPAWN_JITTER_EN.
module barrel_scheduler
    import barrel_pkg::*;
#(
    parameter int NUM_BARRELS    = 4,
    parameter int SPAWN_INTERVAL = 120,
    parameter int FIRST_DELAY    = 30
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_tick,
    input  logic                       game_start,
    input  logic                       game_over,
    input  logic [2*NUM_BARRELS-1:0]   barrel_state,
    input  logic [NUM_BARRELS-1:0]     barrel_retire,
    output logic [NUM_BARRELS-1:0]     barrel_start,
    output logic [NUM_BARRELS-1:0]     barrel_over,
    output logic [NUM_BARRELS-1:0]     active_mask,
    output logic [7:0]                 spawn_count,
    output logic [1:0]                 sched_state
);

    sched_state_t             state;
    logic [9:0]               timer;
    logic [9:0]               reload;
    logic [NUM_BARRELS-1:0]   launched;
    logic [NUM_BARRELS-1:0]   idle;
    logic [NUM_BARRELS-1:0]   free_slots;
    logic [NUM_BARRELS-1:0]   pick;
    logic                     launch;

    function automatic logic [NUM_BARRELS-1:0] lowest_one(input logic [NUM_BARRELS-1:0] v);
        logic found;
        found      = 1'b0;
        lowest_one = '0;
        for (int i = 0; i < NUM_BARRELS; i++) begin
            if (v[i] && !found) begin
                lowest_one[i] = 1'b1;
                found         = 1'b1;
            end
        end
    endfunction

    for (genvar g = 0; g < NUM_BARRELS; g++) begin : g_idle
        assign idle[g] = (barrel_state[2*g +: 2] == B_INITIAL);
    end

    // launched covers the cycle between the start pulse and the barrel leaving INITIAL
    assign free_slots  = idle & ~launched & ~barrel_over;
    assign pick        = lowest_one(free_slots);
    assign launch      = (state == S_RUN) && (timer == '0) && (|free_slots);
    assign active_mask = launched | ~idle;
    assign sched_state = state;

`ifdef BARREL_SPAWN_JITTER_EN
    logic [15:0] lfsr_value;
    logic [10:0] reload_sum;

    spawn_lfsr u_spawn_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (launch),
        .value (lfsr_value)
    );

    assign reload_sum = 11'(SPAWN_INTERVAL) + {6'd0, lfsr_value[4:0]};
    assign reload     = reload_sum[10] ? 10'd1023 : reload_sum[9:0];
`else
    assign reload = 10'(SPAWN_INTERVAL);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            timer        <= '0;
            launched     <= '0;
            barrel_start <= '0;
            barrel_over  <= '0;
            spawn_count  <= '0;
        end else begin
            barrel_start <= '0;
            launched     <= launched & idle;
            case (state)
                S_RUN: begin
                    if (launch) begin
                        barrel_start <= pick;
                        launched     <= (launched & idle) | pick;
                        timer        <= reload;
                        if (spawn_count != 8'hFF) begin
                            spawn_count <= spawn_count + 8'd1;
                        end
                    end else if (frame_tick && (timer != '0)) begin
                        timer <= timer - 10'd1;
                    end
                    if (game_over) begin
                        state       <= S_DRAIN;
                        barrel_over <= '1;
                    end else begin
                        // hold recall until the slot reads INITIAL, then release it
                        barrel_over <= (barrel_over & ~idle)
                                     | (~barrel_over & barrel_retire & active_mask);
                    end
                end
                S_DRAIN: begin
                    if ((&idle) && (launched == '0)) begin
                        state       <= S_IDLE;
                        barrel_over <= '0;
                    end else begin
                        barrel_over <= '1;
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    barrel_over <= '0;
                    if (game_start && !game_over) begin
                        state       <= S_RUN;
                        timer       <= 10'(FIRST_DELAY);
                        spawn_count <= '0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_scheduler.sv
// Scoreboard bench for barrel_scheduler with a small behavioural barrel pool;
// the jitter section is compiled only with BARREL_SPAWN_JITTER_EN.
module tb_barrel_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       frame_tick;
    logic       game_start;
    logic       game_over;
    logic [7:0] barrel_state;
    logic [3:0] barrel_retire;
    logic [3:0] barrel_start;
    logic [3:0] barrel_over;
    logic [3:0] active_mask;
    logic [7:0] spawn_count;
    logic [1:0] sched_state;

    int vec_count = 0;
    int err_count = 0;

    // expected pulse: {barrel_start, spawn_count}
    logic [11:0] exp_q[$];

    logic [1:0] st [4];
    int         pend [4];
    int         hold_cyc [4];
    logic [3:0] drop_req;
    logic       auto_drop;

    barrel_scheduler #(
        .NUM_BARRELS    (4),
        .SPAWN_INTERVAL (4),
        .FIRST_DELAY    (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_tick    (frame_tick),
        .game_start    (game_start),
        .game_over     (game_over),
        .barrel_state  (barrel_state),
        .barrel_retire (barrel_retire),
        .barrel_start  (barrel_start),
        .barrel_over   (barrel_over),
        .active_mask   (active_mask),
        .spawn_count   (spawn_count),
        .sched_state   (sched_state)
    );

    always #5 clk = ~clk;

    // behavioural barrels: roll after start (optionally delayed), drop on request
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst) begin
                st[i]   <= 2'b00;
                pend[i] <= 0;
            end else if (drop_req[i] || (auto_drop && st[i] == 2'b01)) begin
                st[i] <= 2'b00;
            end else if (barrel_start[i]) begin
                if (hold_cyc[i] == 0) st[i] <= 2'b01;
                else pend[i] <= hold_cyc[i];
            end else if (pend[i] > 0) begin
                pend[i] <= pend[i] - 1;
                if (pend[i] == 1) st[i] <= 2'b01;
            end
        end
    end
    assign barrel_state = {st[3], st[2], st[1], st[0]};

    // monitor: every start pulse must match the head of the expected queue
    always @(negedge clk) begin
        if (barrel_start != 4'b0000) begin
            vec_count++;
            if (exp_q.size() == 0) begin
                err_count++;
                $display("FAIL start_unexpected: got start=%b count=%0d, required no pulse",
                         barrel_start, spawn_count);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({barrel_start, spawn_count} !== e) begin
                    err_count++;
                    $display("FAIL start_pulse: got start=%b count=%0d, required start=%b count=%0d",
                             barrel_start, spawn_count, e[11:8], e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic tick_once();
        frame_tick = 1'b1;
        cycles(1);
        frame_tick = 1'b0;
    endtask

    task automatic tick_gap();
        tick_once();
        cycles(9);
    endtask

    // returns at the negedge where a pulse is seen, or after max_cyc cycles
    task automatic wait_start(input string name, input int max_cyc, output int n);
        n = 0;
        @(negedge clk);
        while (barrel_start == 4'b0000 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        vec_count++;
        if (barrel_start == 4'b0000) begin
            err_count++;
            $display("FAIL %s: got no start pulse, required one within %0d cycles", name, max_cyc);
        end
    endtask

    task automatic expect_launch(input int k, input logic [11:0] e, input string name);
        int n;
        repeat (k - 1) tick_gap();
        exp_q.push_back(e);
        tick_once();
        wait_start(name, 4, n);
        check({name, "_latency"}, n, 1);
    endtask

    initial begin
        int n;
        rst = 1'b1; frame_tick = 1'b0; game_start = 1'b0; game_over = 1'b0;
        barrel_retire = 4'b0000; drop_req = 4'b0000; auto_drop = 1'b0;
        for (int i = 0; i < 4; i++) hold_cyc[i] = 0;

        cycles(3);
        check("reset_state", sched_state, 2'b00);
        check("reset_start", barrel_start, 4'b0000);
        check("reset_over", barrel_over, 4'b0000);
        check("reset_active", active_mask, 4'b0000);
        check("reset_count", spawn_count, 8'd0);
        rst = 1'b0;
        cycles(2);
        check("idle_quiet", sched_state, 2'b00);

        // basic launch: first after 2 ticks, then every 4 ticks
        game_start = 1'b1;
        cycles(1);
        game_start = 1'b0;
        check("run_entered", sched_state, 2'b01);
        expect_launch(2, {4'b0001, 8'd1}, "first_launch");
        cycles(1);
        expect_launch(4, {4'b0010, 8'd2}, "second_launch");
        check("count_two", spawn_count, 8'd2);
        check("active_two", active_mask, 4'b0011);

        // slot exhaustion
        cycles(1);
        expect_launch(4, {4'b0100, 8'd3}, "third_launch");
        cycles(1);
        expect_launch(4, {4'b1000, 8'd4}, "fourth_launch");
        cycles(1);
        repeat (6) tick_gap();
        check("exhaust_count", spawn_count, 8'd4);
        check("exhaust_active", active_mask, 4'b1111);
        check("exhaust_nopulse", barrel_start, 4'b0000);

        // retire slot 1, bring it back to INITIAL, expect relaunch without a tick
        barrel_retire = 4'b0010;
        cycles(1);
        barrel_retire = 4'b0000;
        check("retire_over_set", barrel_over, 4'b0010);
        drop_req = 4'b0010;
        cycles(1);
        drop_req = 4'b0000;
        check("retire_over_held", barrel_over, 4'b0010);
        cycles(1);
        check("retire_over_clear", barrel_over, 4'b0000);
        exp_q.push_back({4'b0010, 8'd5});
        wait_start("relaunch_slot1", 4, n);
        cycles(2);

        // game over and drain
        game_over = 1'b1;
        cycles(1);
        check("drain_state", sched_state, 2'b10);
        check("drain_over", barrel_over, 4'b1111);
        game_over  = 1'b0;
        game_start = 1'b1;
        cycles(1);
        game_start = 1'b0;
        check("drain_ignores_start", sched_state, 2'b10);
        for (int i = 0; i < 3; i++) begin
            drop_req = 4'b0001 << i;
            cycles(1);
            drop_req = 4'b0000;
            cycles(1);
        end
        check("drain_holds", sched_state, 2'b10);
        check("drain_over_held", barrel_over, 4'b1111);
        drop_req = 4'b1000;
        cycles(1);
        drop_req = 4'b0000;
        check("drain_last_cycle", sched_state, 2'b10);
        cycles(1);
        check("drain_to_idle", sched_state, 2'b00);
        check("idle_over_clear", barrel_over, 4'b0000);

        // simultaneous start and over in IDLE stays IDLE
        game_start = 1'b1;
        game_over  = 1'b1;
        cycles(1);
        game_start = 1'b0;
        game_over  = 1'b0;
        check("start_over_idle", sched_state, 2'b00);
        check("idle_count_kept", spawn_count, 8'd5);

        // new game; slot 0 stays INITIAL for a while after its start
        hold_cyc[0] = 6;
        game_start = 1'b1;
        cycles(1);
        game_start = 1'b0;
        check("restart_run", sched_state, 2'b01);
        check("restart_count", spawn_count, 8'd0);
        exp_q.push_back({4'b0001, 8'd1});
        frame_tick = 1'b1;
        wait_start("hold_first", 8, n);
        exp_q.push_back({4'b0010, 8'd2});
        wait_start("hold_next_slot1", 10, n);
        check("hold_active", active_mask, 4'b0011);
        hold_cyc[0] = 0;
        exp_q.push_back({4'b0100, 8'd3});
        wait_start("pre_reset_launch", 10, n);

        // reset while the pulse is on the wire
        frame_tick = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_state", sched_state, 2'b00);
        check("midrst_start", barrel_start, 4'b0000);
        check("midrst_over", barrel_over, 4'b0000);
        check("midrst_active", active_mask, 4'b0000);
        check("midrst_count", spawn_count, 8'd0);
        rst = 1'b0;
        cycles(2);

`ifdef BARREL_SPAWN_JITTER_EN
        begin
            logic [15:0] ref_lfsr;
            int          ticks;
            int          seen;
            ref_lfsr  = 16'hACE1;
            ticks     = 0;
            seen      = 0;
            auto_drop = 1'b1;
            for (int k = 1; k <= 9; k++) exp_q.push_back({4'b0001, 8'(k)});
            game_start = 1'b1;
            cycles(1);
            game_start = 1'b0;
            for (int c = 0; c < 2000 && seen < 9; c++) begin
                frame_tick = c[0];
                @(negedge clk);
                if (barrel_start != 4'b0000) begin
                    if (seen > 0) begin
                        check("jitter_interval", ticks, 4 + int'(ref_lfsr[4:0]));
                        ref_lfsr = {1'b0, ref_lfsr[15:1]} ^ (ref_lfsr[0] ? 16'hB400 : 16'h0000);
                    end
                    seen++;
                    ticks = 0;
                end
                if (frame_tick) ticks++;
                @(posedge clk);
                #1;
            end
            frame_tick = 1'b0;
            check("jitter_launches", seen, 9);
            auto_drop = 1'b0;
        end
`endif

        cycles(3);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required finish before time limit");
        $fatal(1);
    end

endmodule
